// File: rtl/abp_sender_ack_receiver.sv
// ABP sender-side ACK frame receiver: checks fixed-length ACK frames from the
// receiver, extracts the alternating bit and compares it with the awaited bit.
module abp_sender_ack_receiver #(
   parameter int FRAME_LEN = 64,
   parameter int CNT_W     = 16
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   input  logic             s_axis_tlast,
   input  logic [7:0]       s_axis_tdata,
   input  logic             expected_bit,
   output logic             ack_valid,
   output logic             ack_bit,
   output logic             ack_match,
   output logic             frame_error,
   output logic             busy,
   output logic [CNT_W-1:0] ack_count,
   output logic [CNT_W-1:0] error_count
);

   localparam int IDX_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      RESET_STATE = 2'd0,
      IDLE        = 2'd1,
      COLLECT     = 2'd2,
      DISCARD     = 2'd3
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic [IDX_W-1:0] beat_cnt_r;
   logic [IDX_W-1:0] beat_cnt_next_s;
   logic             bad_r;
   logic             bad_next_s;
   logic             busy_r;
   logic             busy_next_s;
   logic             tready_r;
   logic             ack_valid_r;
   logic             ack_bit_r;
   logic             ack_match_r;
   logic             frame_error_r;
   logic [CNT_W-1:0] ack_count_r;
   logic [CNT_W-1:0] error_count_r;

   logic             beat_s;
   logic             last_idx_s;
   logic             frame_end_s;
   logic             frame_good_s;

   assign beat_s     = s_axis_tvalid & tready_r;
   assign last_idx_s = (beat_cnt_r == LAST_IDX);

   // State register
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_r <= RESET_STATE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode; also flags the terminating beat and its verdict
   always_comb begin
      state_next_s = state_r;
      frame_end_s  = 1'b0;
      frame_good_s = 1'b0;
      case (state_r)
         RESET_STATE: begin
            state_next_s = IDLE;
         end
         IDLE, COLLECT: begin
            if (beat_s) begin
               if (!last_idx_s) begin
                  if (s_axis_tlast) begin
                     state_next_s = IDLE;
                     frame_end_s  = 1'b1;
                  end else begin
                     state_next_s = COLLECT;
                  end
               end else if (s_axis_tlast) begin
                  state_next_s = IDLE;
                  frame_end_s  = 1'b1;
                  frame_good_s = ~bad_r & (s_axis_tdata[7:1] == 7'h00);
               end else begin
                  state_next_s = DISCARD;
               end
            end else begin
               state_next_s = state_r;
            end
         end
         DISCARD: begin
            if (beat_s && s_axis_tlast) begin
               state_next_s = IDLE;
               frame_end_s  = 1'b1;
            end else begin
               state_next_s = DISCARD;
            end
         end
         default: begin
            state_next_s = RESET_STATE;
         end
      endcase
   end

   // Beat counter, bad flag and busy next values
   always_comb begin
      beat_cnt_next_s = beat_cnt_r;
      bad_next_s      = bad_r;
      busy_next_s     = busy_r;
      if (frame_end_s) begin
         beat_cnt_next_s = {IDX_W{1'b0}};
         bad_next_s      = 1'b0;
         busy_next_s     = 1'b0;
      end else if (beat_s && (state_r == IDLE || state_r == COLLECT)) begin
         busy_next_s = 1'b1;
         if (!last_idx_s) begin
            beat_cnt_next_s = beat_cnt_r + IDX_W'(1'b1);
            bad_next_s      = bad_r | (s_axis_tdata != 8'h00);
         end else begin
            beat_cnt_next_s = beat_cnt_r;
            bad_next_s      = 1'b1;
         end
      end else begin
         beat_cnt_next_s = beat_cnt_r;
      end
   end

   // Registered datapath and outputs; a terminating beat produces its pulse next cycle
   always_ff @(posedge aclk) begin
      if (areset) begin
         tready_r      <= 1'b0;
         beat_cnt_r    <= {IDX_W{1'b0}};
         bad_r         <= 1'b0;
         busy_r        <= 1'b0;
         ack_valid_r   <= 1'b0;
         ack_bit_r     <= 1'b0;
         ack_match_r   <= 1'b0;
         frame_error_r <= 1'b0;
         ack_count_r   <= {CNT_W{1'b0}};
         error_count_r <= {CNT_W{1'b0}};
      end else begin
         tready_r      <= 1'b1;
         beat_cnt_r    <= beat_cnt_next_s;
         bad_r         <= bad_next_s;
         busy_r        <= busy_next_s;
         ack_valid_r   <= frame_end_s & frame_good_s;
         frame_error_r <= frame_end_s & ~frame_good_s;
         if (frame_end_s && frame_good_s) begin
            ack_bit_r   <= s_axis_tdata[0];
            ack_match_r <= (s_axis_tdata[0] == expected_bit);
            ack_count_r <= ack_count_r + CNT_W'(1'b1);
         end else if (frame_end_s) begin
            ack_match_r   <= 1'b0;
            error_count_r <= error_count_r + CNT_W'(1'b1);
         end else begin
            ack_match_r <= ack_match_r;
         end
      end
   end

   assign s_axis_tready = tready_r;
   assign ack_valid     = ack_valid_r;
   assign ack_bit       = ack_bit_r;
   assign ack_match     = ack_match_r;
   assign frame_error   = frame_error_r;
   assign busy          = busy_r;
   assign ack_count     = ack_count_r;
   assign error_count   = error_count_r;

endmodule
